// File: rtl/bcd_display_mux.sv
// rtl/bcd_display_mux.sv - captures a 4-digit BCD result and scans it onto a
// multiplexed common-anode 7-segment display with guard and leading-zero blanking.
module bcd_display_mux #(
  parameter int REFRESH_DIV = 25000,
  parameter bit LZ_BLANK    = 1'b1
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic [15:0] BCD_in,
  input  logic        busy,
  input  logic [3:0]  dp_in,
  input  logic        blank,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an
);

  logic [15:0] presc_q, presc_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] shadow_q, shadow_d;
  logic        busy_d_q;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic [3:0]  an_q, an_d;

  logic        tick;
  logic [3:0]  digit;
  logic        lz_hide;
  logic [6:0]  seg_dec;

  assign tick = (presc_q == 16'(REFRESH_DIV - 1));

  always_comb begin
    digit = 4'h0;
    case (idx_q)
      2'd0: digit = shadow_q[3:0];
      2'd1: digit = shadow_q[7:4];
      2'd2: digit = shadow_q[11:8];
      2'd3: digit = shadow_q[15:12];
      default: digit = 4'h0;
    endcase
  end

  // A digit is hidden only while it and every more significant digit are zero.
  always_comb begin
    lz_hide = 1'b0;
    case (idx_q)
      2'd1: lz_hide = (shadow_q[15:4] == 12'h000);
      2'd2: lz_hide = (shadow_q[15:8] == 8'h00);
      2'd3: lz_hide = (shadow_q[15:12] == 4'h0);
      default: lz_hide = 1'b0;
    endcase
    lz_hide = lz_hide & LZ_BLANK;
  end

  always_comb begin
    seg_dec = 7'h3F;
    case (digit)
      4'd0: seg_dec = 7'h40;
      4'd1: seg_dec = 7'h79;
      4'd2: seg_dec = 7'h24;
      4'd3: seg_dec = 7'h30;
      4'd4: seg_dec = 7'h19;
      4'd5: seg_dec = 7'h12;
      4'd6: seg_dec = 7'h02;
      4'd7: seg_dec = 7'h78;
      4'd8: seg_dec = 7'h00;
      4'd9: seg_dec = 7'h10;
      default: seg_dec = 7'h3F;
    endcase
  end

  always_comb begin
    presc_d  = tick ? 16'h0000 : presc_q + 16'h0001;
    idx_d    = tick ? idx_q + 2'd1 : idx_q;
    shadow_d = (busy_d_q && !busy) ? BCD_in : shadow_q;
    seg_d    = seg_q;
    dp_d     = dp_q;
    an_d     = 4'hF;
    // The slot-change cycle keeps all anodes dark so the old digit never ghosts.
    if (!tick) begin
      seg_d = seg_dec;
      dp_d  = ~dp_in[idx_q];
      an_d  = (blank || lz_hide) ? 4'hF : ~(4'b0001 << idx_q);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      presc_q  <= 16'h0000;
      idx_q    <= 2'd0;
      shadow_q <= 16'h0000;
      busy_d_q <= 1'b0;
      seg_q    <= 7'h7F;
      dp_q     <= 1'b1;
      an_q     <= 4'hF;
    end else begin
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      busy_d_q <= busy;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      an_q     <= an_d;
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

endmodule
